// File: rtl/mul_chain_issuer.sv
// Purpose: gathers bf16 operands into 12 packed slots per mode, fires the multiplier chain once, collects per-lane results and streams them out.
// Latency: ISSUE one cycle after the last operand; DRAIN one cycle after the final lane capture; abort after TIMEOUT WAIT cycles.
// Backpressure: op_ready only in LOAD, cfg_ready only in IDLE; result stream holds res_data until res_valid & res_ready.
module mul_chain_issuer #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_mode,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [15:0]  op_data,
  output logic [191:0] mul_ins,
  output logic         mul_stb,
  output logic [1:0]   mode,
  input  logic [95:0]  outputs,
  input  logic [5:0]   final_output_stbs,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [15:0]  res_data,
  output logic         res_last,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  localparam logic [7:0] TO_CYC = 8'(TIMEOUT);

  // Slot written by the i-th operand of a job in mode m.
  function automatic logic [3:0] slot_of(input logic [1:0] m, input logic [3:0] i);
    logic [3:0] s;
    s = i;
    case (m)
      2'd1: s = 4'(i + i / 4'd3);
      2'd2: begin
        case (i)
          4'd3:    s = 4'd4;
          4'd4:    s = 4'd6;
          4'd5:    s = 4'd7;
          4'd6:    s = 4'd8;
          4'd7:    s = 4'd10;
          default: s = i;
        endcase
      end
      2'd3: begin
        case (i)
          4'd3:    s = 4'd4;
          4'd4:    s = 4'd6;
          4'd5:    s = 4'd8;
          default: s = i;
        endcase
      end
      default: s = i;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] op_total(input logic [1:0] m);
    case (m)
      2'd0:    return 4'd12;
      2'd1:    return 4'd9;
      2'd2:    return 4'd8;
      default: return 4'd6;
    endcase
  endfunction

  function automatic logic [5:0] lane_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 6'b111111;
      2'd1:    return 6'b101010;
      2'd2:    return 6'b100100;
      default: return 6'b010000;
    endcase
  endfunction

  // Lowest masked lane; the first one presented in DRAIN.
  function automatic logic [2:0] first_lane(input logic [5:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int n = 5; n >= 0; n--) if (m[n]) r = 3'(n);
    return r;
  endfunction

  // Lowest masked lane above p; returns p itself when p is the highest.
  function automatic logic [2:0] next_lane(input logic [5:0] m, input logic [2:0] p);
    logic [2:0] r;
    r = p;
    for (int n = 5; n >= 0; n--) if (m[n] && 3'(n) > p) r = 3'(n);
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [11:0][15:0] slots_q;
  logic [5:0][15:0] results_q;
  logic [3:0]       op_cnt_q;
  logic [7:0]       wait_cnt_q;
  logic [5:0]       captured_q;
  logic [2:0]       lane_q;

  logic [5:0] mask;
  logic [5:0] hits;
  logic       all_cap;
  logic       last_op;
  logic       last_lane;
  logic       cfg_fire, op_fire, res_fire, wait_expired;

  assign mask         = lane_mask(mode_q);
  assign hits         = mask & final_output_stbs & ~captured_q;
  assign all_cap      = ((captured_q | hits) == mask);
  assign last_op      = (op_cnt_q == op_total(mode_q) - 4'd1);
  assign last_lane    = (next_lane(mask, lane_q) == lane_q);
  assign cfg_fire     = (state_q == S_IDLE) && cfg_valid;
  assign op_fire      = (state_q == S_LOAD) && op_valid;
  assign res_fire     = (state_q == S_DRAIN) && res_ready;
  assign wait_expired = (wait_cnt_q == TO_CYC);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_fire) state_d = S_LOAD;
      S_LOAD:  if (op_fire && last_op) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (all_cap)           state_d = S_DRAIN;
        else if (wait_expired) state_d = S_IDLE;
      end
      S_DRAIN: if (res_fire && last_lane) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; a capture that completes the mask wins over the timeout.
  always_comb begin
    cfg_ready   = (state_q == S_IDLE);
    op_ready    = (state_q == S_LOAD);
    mul_stb     = (state_q == S_ISSUE);
    busy        = (state_q != S_IDLE);
    res_valid   = (state_q == S_DRAIN);
    res_data    = '0;
    res_last    = 1'b0;
    timeout_err = (state_q == S_WAIT) && wait_expired && !all_cap;
    if (state_q == S_DRAIN) begin
      res_data = results_q[lane_q];
      res_last = last_lane;
    end
  end

  // Job datapath: operand slots, wait counter, lane captures and drain pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 2'd0;
      slots_q    <= '0;
      results_q  <= '0;
      op_cnt_q   <= 4'd0;
      wait_cnt_q <= 8'd0;
      captured_q <= 6'd0;
      lane_q     <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_fire) begin
            mode_q     <= cfg_mode;
            slots_q    <= '0;
            op_cnt_q   <= 4'd0;
            captured_q <= 6'd0;
          end
        end
        S_LOAD: begin
          if (op_fire) begin
            slots_q[slot_of(mode_q, op_cnt_q)] <= op_data;
            op_cnt_q <= op_cnt_q + 4'd1;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= 8'd0;
          captured_q <= 6'd0;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          for (int n = 0; n < 6; n++) begin
            if (hits[n]) results_q[n] <= outputs[16*n +: 16];
          end
          if (all_cap) begin
            captured_q <= captured_q | hits;
            lane_q     <= first_lane(mask);
          end else if (wait_expired) begin
            captured_q <= 6'd0;
          end else begin
            captured_q <= captured_q | hits;
          end
        end
        S_DRAIN: begin
          if (res_fire && !last_lane) lane_q <= next_lane(mask, lane_q);
        end
        default: ;
      endcase
    end
  end

  assign mul_ins = slots_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_mul_chain_issuer.sv
// Purpose: randomized and directed jobs against a queue-based reference of the issuer.
// Latency: expectations are per job (slot image at the issue strobe, lane results in order, abort timing).
// Backpressure: res_ready is randomized and held low in dedicated windows.
module tb_mul_chain_issuer;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready;
  logic [1:0]   cfg_mode;
  logic         op_valid, op_ready;
  logic [15:0]  op_data;
  logic [191:0] mul_ins;
  logic         mul_stb;
  logic [1:0]   mode;
  logic [95:0]  outputs;
  logic [5:0]   final_output_stbs;
  logic         res_valid, res_ready;
  logic [15:0]  res_data;
  logic         res_last;
  logic         busy, timeout_err;

  always #5 clk = ~clk;

  mul_chain_issuer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .mul_ins(mul_ins), .mul_stb(mul_stb), .mode(mode),
    .outputs(outputs), .final_output_stbs(final_output_stbs),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Mode tables: operand slot lists, operand counts, expected lane masks.
  int slot_tab [4][12] = '{'{0,1,2,3,4,5,6,7,8,9,10,11},
                           '{0,1,2,4,5,6,8,9,10,0,0,0},
                           '{0,1,2,4,6,7,8,10,0,0,0,0},
                           '{0,1,2,4,6,8,0,0,0,0,0,0}};
  int         nops_tab [4] = '{12, 9, 8, 6};
  logic [5:0] mask_tab [4] = '{6'b111111, 6'b101010, 6'b100100, 6'b010000};

  typedef struct { logic [15:0] d; logic l; } res_t;

  int errors = 0;
  int checks = 0;

  res_t         exp_q [$];
  logic [15:0]  got [$];
  logic [191:0] exp_ins;
  logic [1:0]   exp_mode;
  logic         chk_ins_on = 1'b0;
  int           cyc = 0, stb_cyc = 0, to_cyc = 0, stb_cnt = 0, to_cnt = 0;
  logic [191:0] stb_ins;
  logic         prev_hold = 1'b0;
  logic [15:0]  prev_data;

  logic [15:0] job_ops  [12];
  logic [5:0]  plan_stb [32];
  logic [95:0] plan_out [32];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the job model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (mul_stb) begin
        stb_cnt++;
        stb_cyc = cyc;
        stb_ins = mul_ins;
        chk("mul_ins_at_stb", mul_ins, exp_ins);
        chk("mode_at_stb", {190'd0, mode}, {190'd0, exp_mode});
      end else if (chk_ins_on) begin
        chk("mul_ins_hold", mul_ins, exp_ins);
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (prev_hold) begin
        chk("hold_valid", {191'd0, res_valid}, 192'd1);
        chk("hold_data", {176'd0, res_data}, {176'd0, prev_data});
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", {191'd0, res_valid}, 192'd0);
        end else begin
          chk("res_data", {176'd0, res_data}, {176'd0, exp_q[0].d});
          chk("res_last", {191'd0, res_last}, {191'd0, exp_q[0].l});
          if (res_ready) begin
            got.push_back(res_data);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
    end
  end

  task automatic check_reset_vals();
    chk("rst_mul_ins", mul_ins, 192'd0);
    chk("rst_mul_stb", {191'd0, mul_stb}, 192'd0);
    chk("rst_mode", {190'd0, mode}, 192'd0);
    chk("rst_res_valid", {191'd0, res_valid}, 192'd0);
    chk("rst_res_data", {176'd0, res_data}, 192'd0);
    chk("rst_res_last", {191'd0, res_last}, 192'd0);
    chk("rst_busy", {191'd0, busy}, 192'd0);
    chk("rst_timeout_err", {191'd0, timeout_err}, 192'd0);
    chk("rst_op_ready", {191'd0, op_ready}, 192'd0);
    chk("rst_cfg_ready", {191'd0, cfg_ready}, 192'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0; final_output_stbs = 6'd0;
    step();
    check_reset_vals();
    rst = 1'b0;
    exp_q.delete();
    chk_ins_on = 1'b0;
  endtask

  task automatic clear_plan();
    for (int c = 0; c < 32; c++) begin
      plan_stb[c] = 6'd0;
      plan_out[c] = {$urandom, $urandom, $urandom};
    end
  endtask

  // abort: 0 = run to completion, 1 = reset after three operands, 2 = reset during DRAIN.
  task automatic run_job(input logic [1:0] m, input int hold_lo, input int abort);
    logic [5:0]  msk, cap, hits;
    logic [15:0] val [6];
    int          hi, guard, hold, dr, exp_n;
    logic        fire, complete;
    msk = mask_tab[m];
    stb_cnt = 0; to_cnt = 0; got.delete(); exp_q.delete(); exp_ins = '0; chk_ins_on = 1'b0;
    hold = hold_lo; dr = 0;
    // operand offered while idle must be ignored
    op_valid = 1'b1; op_data = 16'hDEAD;
    step();
    op_valid = 1'b0;
    guard = 0;
    while (!cfg_ready && guard < 50) begin step(); guard++; end
    chk("cfg_ready_wait", {191'd0, cfg_ready}, 192'd1);
    cfg_valid = 1'b1; cfg_mode = m; exp_mode = m;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < nops_tab[m]; i++) begin
      if (abort == 1 && i == 3) begin do_reset(); return; end
      guard = 0;
      forever begin
        op_valid  = ($urandom_range(0, 3) != 0);
        op_data   = op_valid ? job_ops[i] : 16'hBAD0;
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_mode  = ~m;
        fire = op_valid && op_ready;
        step();
        if (fire) break;
        guard++;
        if (guard > 40) begin chk("op_accept_timeout", 192'd0, 192'd1); break; end
      end
      exp_ins[16*slot_tab[m][i] +: 16] = job_ops[i];
    end
    op_valid = 1'b0; cfg_valid = 1'b0;
    chk("stb_after_load", {191'd0, mul_stb}, 192'd1);
    chk_ins_on = 1'b1;
    // reference: walk the strobe plan over the WAIT window
    cap = 6'd0;
    for (int n = 0; n < 6; n++) val[n] = 16'd0;
    for (int c = 1; c <= TO; c++) begin
      hits = msk & plan_stb[c] & ~cap;
      for (int n = 0; n < 6; n++) if (hits[n]) val[n] = plan_out[c][16*n +: 16];
      cap = cap | hits;
      if (cap == msk) break;
    end
    complete = (cap == msk);
    hi = 0;
    for (int n = 0; n < 6; n++) if (msk[n]) hi = n;
    if (complete)
      for (int n = 0; n < 6; n++) if (msk[n]) exp_q.push_back('{d: val[n], l: (n == hi)});
    exp_n = exp_q.size();
    for (int c = 1; c <= 200; c++) begin
      step();
      if (cfg_ready) break;
      final_output_stbs = (c < 32) ? plan_stb[c] : 6'd0;
      outputs           = (c < 32) ? plan_out[c] : {$urandom, $urandom, $urandom};
      if (abort == 2 && res_valid) begin
        dr++;
        if (dr == 3) begin do_reset(); return; end
        res_ready = 1'b0;
      end else if (res_valid && hold > 0) begin
        res_ready = 1'b0;
        hold--;
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      if (c == 200) chk("job_end_timeout", 192'd0, 192'd1);
    end
    final_output_stbs = 6'd0; res_ready = 1'b0;
    chk_ins_on = 1'b0;
    chk("stb_count", stb_cnt, 192'd1);
    chk("result_count", got.size(), exp_n);
    chk("queue_empty", exp_q.size(), 192'd0);
    chk("idle_busy", {191'd0, busy}, 192'd0);
    if (complete) begin
      chk("no_timeout", to_cnt, 192'd0);
    end else begin
      chk("timeout_count", to_cnt, 192'd1);
      chk("timeout_delay", to_cyc - stb_cyc, TO + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    logic [5:0] msk;
    int         c1, c2;
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; op_valid = 1'b0; op_data = 16'd0;
    outputs = '0; final_output_stbs = 6'd0; res_ready = 1'b0;
    step(); step();
    check_reset_vals();
    rst = 1'b0;
    step();

    // two_in: alternating operands, all six lanes strobe together
    for (int i = 0; i < 12; i++) job_ops[i] = (i % 2 == 0) ? 16'h3F80 : 16'h4000;
    clear_plan();
    plan_stb[1] = 6'b111111; plan_out[1] = {6{16'h4000}};
    run_job(2'd0, 0, 0);
    chk("lit_two_in_slots", stb_ins, {6{16'h4000, 16'h3F80}});
    chk("lit_two_in_count", got.size(), 192'd6);
    chk("lit_two_in_first", {176'd0, got[0]}, 192'h4000);
    chk("lit_two_in_sixth", {176'd0, got[5]}, 192'h4000);

    // three_in: lanes 1,3,5 in separate cycles
    for (int i = 0; i < 9; i++) job_ops[i] = (i % 3 == 0) ? 16'h4000 : (i % 3 == 1) ? 16'h4040 : 16'h3F80;
    clear_plan();
    plan_stb[2] = 6'b000010; plan_out[2][31:16]  = 16'h40C0;
    plan_stb[4] = 6'b001000; plan_out[4][63:48]  = 16'h40C0;
    plan_stb[6] = 6'b100000; plan_out[6][95:80]  = 16'h40C0;
    run_job(2'd1, 0, 0);
    chk("lit_three_in_gaps", {stb_ins[191:176], stb_ins[127:112], stb_ins[63:48]}, 192'd0);
    chk("lit_three_in_slot2", {176'd0, stb_ins[47:32]}, 192'h3F80);
    chk("lit_three_in_count", got.size(), 192'd3);
    chk("lit_three_in_vals", {144'd0, got[0], got[1], got[2]}, {144'd0, {3{16'h40C0}}});

    // six_in: spurious strobes before the lane-4 strobe
    for (int i = 0; i < 6; i++) job_ops[i] = 16'(16'h3F00 + i);
    clear_plan();
    plan_stb[1] = 6'b101111;
    plan_stb[3] = 6'b010000; plan_out[3][79:64] = 16'h1234;
    run_job(2'd3, 0, 0);
    chk("lit_six_in_count", got.size(), 192'd1);
    chk("lit_six_in_val", {176'd0, got[0]}, 192'h1234);

    // four_in: only lane 2 strobes -> abort
    for (int i = 0; i < 8; i++) job_ops[i] = 16'(16'h4100 + i);
    clear_plan();
    plan_stb[3] = 6'b000100;
    run_job(2'd2, 0, 0);
    chk("lit_timeout_delay", to_cyc - stb_cyc, 192'd17);
    chk("lit_timeout_nores", got.size(), 192'd0);

    // DRAIN backpressure window, then resets mid-LOAD and mid-DRAIN, then a fresh job
    for (int i = 0; i < 12; i++) job_ops[i] = 16'($urandom);
    clear_plan();
    plan_stb[2] = 6'b111111;
    run_job(2'd0, 5, 0);
    run_job(2'd1, 0, 1);
    clear_plan();
    plan_stb[1] = 6'b111111;
    run_job(2'd0, 0, 2);
    clear_plan();
    plan_stb[2] = 6'b100100;
    run_job(2'd2, 0, 0);
    chk("lit_fresh_count", got.size(), 192'd2);

    // randomized jobs: random strobe timing, duplicates, spurious lanes, occasional missing lane
    for (int j = 0; j < 30; j++) begin
      m   = 2'($urandom_range(0, 3));
      msk = mask_tab[m];
      for (int i = 0; i < 12; i++) job_ops[i] = 16'($urandom);
      clear_plan();
      for (int c = 1; c < 32; c++) plan_stb[c] = 6'($urandom) & ~msk;
      for (int n = 0; n < 6; n++) begin
        if (msk[n] && $urandom_range(0, 11) != 0) begin
          c1 = $urandom_range(1, 12);
          c2 = $urandom_range(c1, 20);
          plan_stb[c1][n] = 1'b1;
          plan_stb[c2][n] = 1'b1;
        end
      end
      run_job(m, $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
